nway_cache: RTL and testbench
=============================

# nway_cache

Parametrised N-way set-associative, write-back, write-allocate cache with tree-PLRU replacement. It is the generalised successor of the fixed 2-way cache. Controller, tag/data arrays and replacement logic live in one block. It sits between a single CPU request port and a block-wide memory port that uses ready/valid handshakes.

## Interface
- WORD_SIZE, 32, bits per word
- WORDS_PER_BLOCK, 4, words per line (power of 2, ≥2)
- NUM_SETS, 16, sets (power of 2)
- NUM_WAYS, 4, ways per set (power of 2, ≥2)
- ADDR_WIDTH, 32, word-address width
- Derived:
  - OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK)
  - INDEX_WIDTH = $clog2(NUM_SETS)
  - TAG_WIDTH = ADDR_WIDTH − INDEX_WIDTH − OFFSET_WIDTH
  - BLOCK_SIZE = WORDS_PER_BLOCK*WORD_SIZE
- Ports:
  - clk  in  1  clock, all logic on posedge
  - rst  in  1  asynchronous, active-high reset
  - req_valid  in  1  CPU request valid
  - req_ready  out  1  cache accepts request
  - req_type  in  1  0 = read, 1 = write
  - address  in  ADDR_WIDTH  word address {tag, index, offset}
  - data_in  in  WORD_SIZE  write data
  - resp_valid  out  1  one-cycle completion pulse
  - data_out  out  WORD_SIZE  read data, valid with resp_valid
  - mem_req_valid  out  1  memory request valid
  - mem_req_ready  in  1  memory accepts request
  - mem_req_we  out  1  1 = write-back, 0 = refill read
  - mem_addr  out  ADDR_WIDTH  line address, offset bits zero
  - mem_wdata  out  BLOCK_SIZE  victim line
  - mem_resp_valid  in  1  refill data valid
  - mem_rdata  in  BLOCK_SIZE  refill line
  - hit_count, miss_count  out  32 each  wrapping event counters

## Operation
- States: IDLE, COMPARE, WRITE_BACK, REFILL_REQ, REFILL_WAIT.
- IDLE: req_ready=1.
  - A request is accepted when req_valid&&req_ready.
  - On acceptance, address, req_type and data_in are latched → COMPARE.
  - req_ready=0 in every other state. Requests offered then are neither dropped nor stored; the CPU holds them.
- COMPARE: all ways of the set are compared in parallel. Hit = valid && tag match, and at most one way hits.
  - Read hit: data_out/resp_valid are registered from the hit word.
  - Write hit: the hit word is replaced and dirty is set.
  - Either hit: PLRU updates, hit_count++, → IDLE.
  - Miss: miss_count++, victim chosen.
    - Victim = lowest-numbered invalid way; if none, the PLRU victim.
    - Victim dirty → WRITE_BACK, else → REFILL_REQ.
- WRITE_BACK: mem_req_valid=1, mem_req_we=1, mem_addr={victim_tag,index,0}, mem_wdata=victim line.
  - These are held stable until mem_req_ready.
  - Handshake completes the write-back; victim dirty is cleared → REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, mem_req_we=0, mem_addr={tag,index,0}. On mem_req_ready → REFILL_WAIT.
- REFILL_WAIT: waits for mem_resp_valid, then installs the line into the victim way with valid=1 and tag=latched tag.
  - Write miss: the target word is replaced by data_in and dirty=1.
  - Read miss: dirty=0, and data_out = the target word of mem_rdata.
  - resp_valid pulses, PLRU updates, → IDLE.
- Tree PLRU: NUM_WAYS−1 bits per set.
  - Node bit 0 means the victim lies in the left subtree.
  - Every hit or fill sets each node on the accessed path to point away from the accessed way.
- mem_resp_valid outside REFILL_WAIT is ignored. mem_req_ready outside the request states is ignored.

## Timing
- Reset values (asynchronous):
  - Registers: state=IDLE, resp_valid=0, data_out=0, counters=0.
  - Array state: all valid, dirty and PLRU bits = 0.
  - Tag/data arrays are not reset.
  - Combinational outputs in IDLE: req_ready=1, mem_req_valid=0.
- Hit latency: request accepted at edge T → resp_valid high during cycle T+2 (COMPARE occupies T+1). A new request can be accepted in the resp_valid cycle.
- Clean miss: resp_valid appears 1 cycle after the edge that sampled mem_resp_valid.
- Dirty miss: adds the write-back handshake ahead of the refill request.
- resp_valid is exactly one cycle wide. data_out holds its value until the next response.
- Reset mid-operation: mem_req_valid and resp_valid drop immediately, and every line becomes invalid. Dirty data is lost; the environment must not rely on it.
- Counters wrap at 2^32.

## Test plan
Defaults are used throughout. Lines in set 0 have address = tag<<6.
- Cold read 0x40 → memory read with mem_addr=0x40. Returning mem_rdata word0=0xAAAA_0001 → data_out=0xAAAA_0001 with resp_valid; miss_count=1.
- Read 0x40 again → resp_valid 2 cycles after acceptance, data 0xAAAA_0001, no memory request, hit_count=1.
- Write 0x41 data 0x1234_5678 (hit), then fill tags 2,3,4 and read tag 5. Victim is way0 (tag1, dirty) → write-back at mem_addr=0x40 whose mem_wdata word1=0x1234_5678. Refill of 0x140 follows.
- PLRU: fill tags 1–4 (ways 0–3), re-read tag1, then read tag5 → way2 (tag3) is replaced. A subsequent read of tag3 misses, and a read of tag1 hits.
- Hold mem_req_ready=0 for 5 cycles during a refill request → mem_req_valid, mem_addr and mem_req_we stay stable, req_ready=0, and an extra req_valid pulse is not accepted.
- Assert rst during REFILL_WAIT → outputs take reset values at once. After release, a read of the same address misses again and issues a new refill.

Source files
------------

// File: rtl/nway_cache_if.sv
// rtl/nway_cache_if.sv - CPU request/response and block-memory handshake bundle for nway_cache
interface nway_cache_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 128
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_type;
  logic [ADDR_WIDTH-1:0] address;
  logic [WORD_SIZE-1:0]  data_in;
  logic                  resp_valid;
  logic [WORD_SIZE-1:0]  data_out;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic                  mem_resp_valid;
  logic [BLOCK_SIZE-1:0] mem_rdata;

  // master: the CPU and memory around the cache; slave: the cache itself
  modport master (
    output req_valid, req_type, address, data_in, mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, data_out, mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_type, address, data_in, mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, data_out, mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nway_cache.sv
// rtl/nway_cache.sv - N-way set-associative write-back, write-allocate cache with tree-PLRU replacement
module nway_cache #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 16,
  parameter int NUM_WAYS        = 4,
  parameter int ADDR_WIDTH      = 32,
  localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
  localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
  localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int BLOCK_SIZE     = WORDS_PER_BLOCK * WORD_SIZE,
  localparam int WAY_W          = $clog2(NUM_WAYS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  nway_cache_if.slave   bus,
  output logic [31:0]   hit_count_o,
  output logic [31:0]   miss_count_o
);
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_COMPARE     = 3'd1;
  localparam logic [2:0] S_WRITE_BACK  = 3'd2;
  localparam logic [2:0] S_REFILL_REQ  = 3'd3;
  localparam logic [2:0] S_REFILL_WAIT = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  type_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  resp_valid_q;
  logic [WORD_SIZE-1:0]  data_out_q;
  logic [31:0]           hit_cnt_q, miss_cnt_q;

  logic [NUM_SETS-1:0]   valid_q [NUM_WAYS];
  logic [NUM_SETS-1:0]   dirty_q [NUM_WAYS];
  logic [NUM_WAYS-2:0]   plru_q  [NUM_SETS];
  logic [TAG_WIDTH-1:0]  tag_q   [NUM_WAYS][NUM_SETS];
  logic [BLOCK_SIZE-1:0] data_q  [NUM_WAYS][NUM_SETS];

  logic [INDEX_WIDTH-1:0]  idx;
  logic [OFFSET_WIDTH-1:0] off;
  logic [TAG_WIDTH-1:0]    tag;
  assign idx = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign off = addr_q[OFFSET_WIDTH-1:0];
  assign tag = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];

  // Walk root to leaf; a node bit of 0 sends the victim search into the left subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    int                  node;
    logic [WAY_W-1:0]    way;
    logic [NUM_WAYS-2:0] sh;
    node = 0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      sh   = bits >> node;
      way  = (way << 1) | WAY_W'(sh[0]);
      node = 2 * node + 1 + (sh[0] ? 1 : 0);
    end
    return way;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                     input logic [WAY_W-1:0] way);
    int                  node;
    logic [WAY_W-1:0]    w;
    logic [NUM_WAYS-2:0] m;
    logic                b;
    node = 0;
    w    = way;
    for (int l = 0; l < WAY_W; l++) begin
      b    = w[WAY_W-1];
      w    = w << 1;
      m    = (NUM_WAYS-1)'(1) << node;
      bits = b ? (bits & ~m) : (bits | m);
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return bits;
  endfunction

  function automatic logic [WORD_SIZE-1:0] word_of(input logic [BLOCK_SIZE-1:0] line,
                                                   input logic [OFFSET_WIDTH-1:0] o);
    logic [BLOCK_SIZE-1:0] sh;
    sh = line >> (int'(o) * WORD_SIZE);
    return sh[WORD_SIZE-1:0];
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0] line,
                                                     input logic [OFFSET_WIDTH-1:0] o,
                                                     input logic [WORD_SIZE-1:0] word);
    logic [BLOCK_SIZE-1:0] m;
    m = BLOCK_SIZE'({WORD_SIZE{1'b1}}) << (int'(o) * WORD_SIZE);
    return (line & ~m) | (BLOCK_SIZE'(word) << (int'(o) * WORD_SIZE));
  endfunction

  logic             hit, has_free;
  logic [WAY_W-1:0] hit_way, free_way, victim_sel;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    victim_sel = has_free ? free_way : plru_victim(plru_q[idx]);
  end

  logic                  line_we, tag_we;
  logic [WAY_W-1:0]      line_way;
  logic [BLOCK_SIZE-1:0] line_wdata;

  always_comb begin
    state_d    = state_q;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_way   = hit_way;
    line_wdata = data_q[hit_way][idx];
    case (state_q)
      S_IDLE: if (bus.req_valid) state_d = S_COMPARE;
      S_COMPARE: begin
        if (hit) begin
          state_d = S_IDLE;
          if (type_q) begin
            line_we    = 1'b1;
            line_wdata = put_word(data_q[hit_way][idx], off, wdata_q);
          end
        end else begin
          state_d = dirty_q[victim_sel][idx] ? S_WRITE_BACK : S_REFILL_REQ;
        end
      end
      S_WRITE_BACK: if (bus.mem_req_ready) state_d = S_REFILL_REQ;
      S_REFILL_REQ: if (bus.mem_req_ready) state_d = S_REFILL_WAIT;
      S_REFILL_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d    = S_IDLE;
          line_we    = 1'b1;
          tag_we     = 1'b1;
          line_way   = victim_q;
          line_wdata = type_q ? put_word(bus.mem_rdata, off, wdata_q) : bus.mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (line_we) data_q[line_way][idx] <= line_wdata;
    if (tag_we)  tag_q[line_way][idx]  <= tag;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      type_q       <= 1'b0;
      wdata_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      data_out_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.address;
            type_q  <= bus.req_type;
            wdata_q <= bus.data_in;
          end
        end
        S_COMPARE: begin
          if (hit) begin
            hit_cnt_q    <= hit_cnt_q + 32'd1;
            resp_valid_q <= 1'b1;
            plru_q[idx]  <= plru_touch(plru_q[idx], hit_way);
            if (type_q) dirty_q[hit_way][idx] <= 1'b1;
            else        data_out_q <= word_of(data_q[hit_way][idx], off);
          end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
            victim_q   <= victim_sel;
          end
        end
        S_WRITE_BACK: if (bus.mem_req_ready) dirty_q[victim_q][idx] <= 1'b0;
        S_REFILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= type_q;
            plru_q[idx]            <= plru_touch(plru_q[idx], victim_q);
            resp_valid_q           <= 1'b1;
            if (!type_q) data_out_q <= word_of(bus.mem_rdata, off);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.resp_valid    = resp_valid_q;
  assign bus.data_out      = data_out_q;
  assign bus.mem_req_valid = (state_q == S_WRITE_BACK) || (state_q == S_REFILL_REQ);
  assign bus.mem_req_we    = (state_q == S_WRITE_BACK);
  assign bus.mem_addr      = {(state_q == S_WRITE_BACK) ? tag_q[victim_q][idx] : tag, idx,
                              {OFFSET_WIDTH{1'b0}}};
  assign bus.mem_wdata     = data_q[victim_q][idx];
  assign hit_count_o       = hit_cnt_q;
  assign miss_count_o      = miss_cnt_q;
endmodule

// File: tb/tb_nway_cache.sv
// tb/tb_nway_cache.sv - self-checking bench for nway_cache with a behavioural cache and memory model
module tb_nway_cache;
  localparam int WS = 32, WPB = 4, NS = 16, NW = 4, AW = 32, BS = WS * WPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nway_cache_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();
  logic [31:0] hit_count, miss_count;

  nway_cache #(.WORD_SIZE(WS), .WORDS_PER_BLOCK(WPB), .NUM_SETS(NS), .NUM_WAYS(NW),
               .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .hit_count_o(hit_count), .miss_count_o(miss_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit we; logic [31:0] addr; logic [BS-1:0] wdata; } memop_t;
  typedef struct { bit rd; logic [31:0] data; int hits; int misses; bit hit; int acc; } resp_t;
  memop_t exp_mem[$];
  resp_t  exp_resp[$];

  bit          m_valid [NS][NW];
  bit          m_dirty [NS][NW];
  logic [25:0] m_tag   [NS][NW];
  logic [31:0] m_data  [NS][NW][WPB];
  bit          m_plru  [NS][NW-1];
  int          m_hits, m_misses;
  logic [BS-1:0] model_mem [int unsigned];

  function automatic logic [BS-1:0] init_line(input logic [31:0] la);
    logic [BS-1:0] l;
    for (int w = 0; w < WPB; w++)
      l[w*WS +: WS] = 32'hAAAA_0000 + (la >> 6) + ((la >> 2) % 16) * 256 + w * 4096;
    return l;
  endfunction

  // Victim search narrows a range of ways by halves, following the node bits.
  function automatic int m_victim(input int s);
    int lo = 0, span = NW, node = 0;
    while (span > 1) begin
      span = span / 2;
      if (m_plru[s][node]) begin lo += span; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int lo = 0, span = NW, node = 0;
    while (span > 1) begin
      span = span / 2;
      if (w >= lo + span) begin m_plru[s][node] = 0; lo += span; node = 2 * node + 2; end
      else begin m_plru[s][node] = 1; node = 2 * node + 1; end
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
      for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 0;
    end
    m_hits = 0;
    m_misses = 0;
    exp_mem.delete();
    exp_resp.delete();
  endtask

  task automatic model_access(input bit typ, input logic [31:0] a, input logic [31:0] d,
                              input int acc);
    int s = int'(a[5:2]);
    int o = int'(a[1:0]);
    logic [25:0] t = a[31:6];
    int hw = -1, v = -1;
    logic [BS-1:0] line;
    logic [31:0] la;
    resp_t r;
    for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      m_hits++;
      if (typ) begin m_data[s][hw][o] = d; m_dirty[s][hw] = 1; end
      m_touch(s, hw);
      r = '{rd: !typ, data: m_data[s][hw][o], hits: m_hits, misses: m_misses, hit: 1, acc: acc};
    end else begin
      m_misses++;
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) v = m_victim(s);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        for (int w = 0; w < WPB; w++) line[w*WS +: WS] = m_data[s][v][w];
        la = {m_tag[s][v], 4'(s), 2'b00};
        model_mem[la] = line;
        exp_mem.push_back('{we: 1, addr: la, wdata: line});
      end
      la = {t, 4'(s), 2'b00};
      exp_mem.push_back('{we: 0, addr: la, wdata: '0});
      line = model_mem.exists(la) ? model_mem[la] : init_line(la);
      for (int w = 0; w < WPB; w++) m_data[s][v][w] = line[w*WS +: WS];
      m_valid[s][v] = 1;
      m_tag[s][v]   = t;
      m_dirty[s][v] = typ;
      if (typ) m_data[s][v][o] = d;
      m_touch(s, v);
      r = '{rd: !typ, data: m_data[s][v][o], hits: m_hits, misses: m_misses, hit: 0, acc: acc};
    end
    exp_resp.push_back(r);
  endtask

  // ---------------- memory responder ----------------
  int stall_left = 0;
  int resp_delay = 2;
  int resp_cnt   = 0;
  int last_mresp_cyc = -10;
  logic [BS-1:0] resp_line;
  logic [BS-1:0] mem_store [int unsigned];

  initial begin
    bus.mem_req_ready  = 0;
    bus.mem_resp_valid = 0;
    bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 0;
      if (rst) begin
        resp_cnt = 0;
        bus.mem_req_ready = 0;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            bus.mem_resp_valid = 1;
            bus.mem_rdata = resp_line;
            last_mresp_cyc = cyc;
          end
        end
        if (bus.mem_req_valid) begin
          if (stall_left > 0) begin
            stall_left--;
            bus.mem_req_ready = 0;
          end else begin
            bus.mem_req_ready = 1;
            if (bus.mem_req_we) mem_store[bus.mem_addr] = bus.mem_wdata;
            else begin
              resp_line = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                          : init_line(bus.mem_addr);
              resp_cnt = resp_delay;
            end
          end
        end else bus.mem_req_ready = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0]   last_rd_addr = '0, last_wb_addr = '0;
  logic [BS-1:0] last_wb_data = '0;
  bit            hold_active = 0;
  logic [31:0]   held_addr;
  logic          held_we;

  initial begin
    memop_t e;
    resp_t  r;
    forever begin
      @(negedge clk);
      #1;
      if (rst) hold_active = 0;
      else begin
        if (bus.mem_req_valid) begin
          if (hold_active) begin
            check("mem_addr stable", bus.mem_addr, held_addr);
            check("mem_req_we stable", bus.mem_req_we, held_we);
          end
          hold_active = !bus.mem_req_ready;
          held_addr = bus.mem_addr;
          held_we = bus.mem_req_we;
        end else if (hold_active) begin
          check("mem_req_valid dropped while stalled", bus.mem_req_valid, 1);
          hold_active = 0;
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (exp_mem.size() == 0) check("unexpected mem request", 1, 0);
          else begin
            e = exp_mem.pop_front();
            check("mem_req_we", bus.mem_req_we, e.we);
            check("mem_addr", bus.mem_addr, e.addr);
            if (e.we) begin
              check("mem_wdata", bus.mem_wdata, e.wdata);
              last_wb_addr = bus.mem_addr;
              last_wb_data = bus.mem_wdata;
            end else last_rd_addr = bus.mem_addr;
          end
        end
        if (bus.resp_valid) begin
          if (exp_resp.size() == 0) check("unexpected resp_valid", 1, 0);
          else begin
            r = exp_resp.pop_front();
            if (r.rd) check("data_out", bus.data_out, r.data);
            check("hit_count", hit_count, r.hits);
            check("miss_count", miss_count, r.misses);
            if (r.hit) check("hit latency", cyc, r.acc + 2);
            else       check("miss latency", cyc, last_mresp_cyc + 1);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input bit typ, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.req_ready) check("req_ready timeout", 0, 1);
    else begin
      bus.req_valid = 1;
      bus.req_type  = typ;
      bus.address   = a;
      bus.data_in   = d;
      model_access(typ, a, d, cyc);
      @(posedge clk);
      #1 bus.req_valid = 0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_resp.size() != 0 || exp_mem.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("response timeout", (exp_resp.size() != 0 || exp_mem.size() != 0), 0);
  endtask

  task automatic rd(input logic [31:0] a);
    access(0, a, 32'h0);
    wait_done();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1;
    #1;
    check("rst req_ready", bus.req_ready, 1);
    check("rst mem_req_valid", bus.mem_req_valid, 0);
    check("rst resp_valid", bus.resp_valid, 0);
    check("rst data_out", bus.data_out, 0);
    check("rst hit_count", hit_count, 0);
    check("rst miss_count", miss_count, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 0;
    bus.req_type  = 0;
    bus.address   = '0;
    bus.data_in   = '0;
    m_reset();
    repeat (2) @(negedge clk);
    check("reset req_ready", bus.req_ready, 1);
    check("reset mem_req_valid", bus.mem_req_valid, 0);
    check("reset resp_valid", bus.resp_valid, 0);
    check("reset counters", {hit_count, miss_count}, 0);
    rst = 0;

    // cold miss, hit, dirty write, dirty victim write-back
    rd(32'h40);
    check("cold refill addr", last_rd_addr, 32'h40);
    check("cold data", bus.data_out, 32'hAAAA_0001);
    check("cold miss_count", miss_count, 1);
    rd(32'h40);
    check("hit_count after reread", hit_count, 1);
    access(1, 32'h41, 32'h1234_5678);
    wait_done();
    rd(32'h80);
    rd(32'hC0);
    rd(32'h100);
    rd(32'h140);
    check("wb addr", last_wb_addr, 32'h40);
    check("wb word1", last_wb_data[63:32], 32'h1234_5678);
    check("refill after wb", last_rd_addr, 32'h140);
    rd(32'h41);
    check("written word returns", bus.data_out, 32'h1234_5678);

    // PLRU ordering
    reset_pulse();
    rd(32'h40); rd(32'h80); rd(32'hC0); rd(32'h100);
    rd(32'h40);
    rd(32'h140);
    rd(32'hC0);
    check("plru tag3 evicted", last_rd_addr, 32'hC0);
    check("plru miss_count", miss_count, 6);
    rd(32'h40);
    check("plru tag1 kept", hit_count, 2);

    // other sets, write miss then read hit
    access(1, 32'h7, 32'hDEAD_BEEF);
    wait_done();
    rd(32'h7);
    rd(32'h3D);

    // refill request stalled by memory; extra CPU pulse must be ignored
    stall_left = 5;
    access(0, 32'h1C4, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("stall req_ready", bus.req_ready, 0);
    check("stall mem_req_valid", bus.mem_req_valid, 1);
    bus.req_valid = 1;
    bus.req_type  = 0;
    bus.address   = 32'h80;
    @(negedge clk);
    bus.req_valid = 0;
    wait_done();

    // reset while waiting for refill data
    resp_delay = 20;
    access(0, 32'h200, 32'h0);
    n = 0;
    while (exp_mem.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("refill issued before reset", exp_mem.size(), 0);
    repeat (2) @(negedge clk);
    reset_pulse();
    resp_delay = 2;
    rd(32'h200);
    check("post-reset refill addr", last_rd_addr, 32'h200);
    check("post-reset miss_count", miss_count, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
